dec_conv_sched: RTL and testbench

Time-shares one iterative 8-bit binary-to-BCD (double-dabble) converter among the CPU I/O ports that drive the digitron display (PAN, out_port1, out_port2). The scheduler sits between `sc_computer_main` and `display` and replaces three combinational `out_port_hex2dec` instances. It polls ports round-robin and converts only ports whose value changed since their last conversion. It holds a tens/units digit pair plus an overflow flag per port for the display unit.

---
 rtl/io_pkg.sv | 22 ++
 rtl/dec_conv_sched_if.sv | 27 ++
 rtl/dec_conv_sched_dd_step.sv | 23 ++
 rtl/dec_conv_sched.sv | 163 ++++++++++++++++
 tb/tb_dec_conv_sched.sv | 151 +++++++++++++++
 5 files changed

// File: rtl/io_pkg.sv
// Shared definitions for the digitron display BCD conversion scheduler.
// Latency: n/a (types, constants and one helper function only).
// Backpressure: n/a.
package io_pkg;

    typedef enum logic [1:0] {
        SEL   = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2,
        STORE = 2'd3
    } state_t;

    localparam int         IO_PORT_W = 32;
    localparam logic [3:0] BCD_SAT   = 4'd9;

    // Double-dabble correction: a digit of 5 or more becomes >= 10 after the
    // next doubling, so it is pre-biased by 3 to carry into the next digit.
    function automatic logic [3:0] add3(input logic [3:0] n);
        return (n >= 4'd5) ? n + 4'd3 : n;
    endfunction

endpackage

// File: rtl/dec_conv_sched_if.sv
// Bundle between the CPU I/O ports and the display: raw port values in, BCD digits out.
// Latency: n/a (signal bundle only).
// Backpressure: none; digits are level outputs held until the next conversion.
// Ports: in_data (NPORT x 32b, port p at [p*32+:32]), tens/units (NPORT x 4b),
//        ovf (NPORT), busy, cur_port (2b round-robin pointer).
interface dec_conv_sched_if #(
    parameter int NPORT = 3
);
    logic [NPORT*32-1:0] in_data;
    logic [NPORT*4-1:0]  tens;
    logic [NPORT*4-1:0]  units;
    logic [NPORT-1:0]    ovf;
    logic                busy;
    logic [1:0]          cur_port;

    // master drives the port values and consumes the digits
    modport master (
        output in_data,
        input  tens, units, ovf, busy, cur_port
    );

    // slave is the scheduler itself
    modport slave (
        input  in_data,
        output tens, units, ovf, busy, cur_port
    );
endinterface

// File: rtl/dec_conv_sched_dd_step.sv
// One double-dabble iteration: add-3 correction on each BCD digit, then shift {bcd, sh} left by one.
// Latency: combinational.
// Backpressure: none.
// Ports: bcd_i/sh_i current accumulator and binary shift register; bcd_o/sh_o after one step.
import io_pkg::*;

module dd_step #(
    parameter int CW = 8
) (
    input  logic [11:0]   bcd_i,
    input  logic [CW-1:0] sh_i,
    output logic [11:0]   bcd_o,
    output logic [CW-1:0] sh_o
);

    logic [11:0] bcd_adj;

    always_comb begin
        bcd_adj       = {add3(bcd_i[11:8]), add3(bcd_i[7:4]), add3(bcd_i[3:0])};
        {bcd_o, sh_o} = {bcd_adj, sh_i} << 1;
    end

endmodule

// File: rtl/dec_conv_sched.sv
// Round-robin scheduler sharing one iterative 8-bit binary-to-BCD converter among NPORT display ports.
// Latency: CW+2 cycles per conversion; digits visible 11 cycles after the SEL cycle that picks a port.
// Backpressure: none; unchanged ports are skipped, changed ports wait their round-robin turn.
// Ports: clk, reset (async, active-high), bus (slave modport: in_data in; tens/units/ovf/busy/cur_port out).
import io_pkg::*;

module dec_conv_sched #(
    parameter int NPORT = 3,
    parameter int CW    = 8
) (
    input  logic             clk,
    input  logic             reset,
    dec_conv_sched_if.slave  bus
);

    localparam int PW   = 2;
    localparam int CNTW = $clog2(CW);

    // per-port views of the flattened bus
    logic [IO_PORT_W-1:0] in_arr [NPORT];

    // scheduler state
    state_t               state_q, state_d;
    logic [PW-1:0]        ptr_q, ptr_d, ptr_nxt;
    logic                 busy_q, busy_d;

    // converter datapath
    logic [IO_PORT_W-1:0] snap_q, snap_d;
    logic [CW-1:0]        sh_q, sh_d, step_sh;
    logic [11:0]          bcd_q, bcd_d, step_bcd;
    logic [CNTW-1:0]      cnt_q, cnt_d;
    logic                 hi_nz_q, hi_nz_d;

    // per-port bookkeeping and output registers
    logic [IO_PORT_W-1:0] last_q  [NPORT];
    logic [IO_PORT_W-1:0] last_d  [NPORT];
    logic [NPORT-1:0]     vld_q, vld_d;
    logic [3:0]           tens_q  [NPORT];
    logic [3:0]           tens_d  [NPORT];
    logic [3:0]           units_q [NPORT];
    logic [3:0]           units_d [NPORT];
    logic [NPORT-1:0]     ovf_q, ovf_d;

    logic [IO_PORT_W-1:0] cur_in;

    for (genvar p = 0; p < NPORT; p++) begin : g_port
        assign in_arr[p]          = bus.in_data[p*IO_PORT_W +: IO_PORT_W];
        assign bus.tens[p*4 +: 4]  = tens_q[p];
        assign bus.units[p*4 +: 4] = units_q[p];
    end

    assign bus.ovf      = ovf_q;
    assign bus.busy     = busy_q;
    assign bus.cur_port = ptr_q;

    assign cur_in  = in_arr[ptr_q];
    assign ptr_nxt = (ptr_q == PW'(NPORT-1)) ? '0 : ptr_q + 1'b1;

    dd_step #(.CW(CW)) u_dd_step (
        .bcd_i (bcd_q),
        .sh_i  (sh_q),
        .bcd_o (step_bcd),
        .sh_o  (step_sh)
    );

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        snap_d  = snap_q;
        sh_d    = sh_q;
        bcd_d   = bcd_q;
        cnt_d   = cnt_q;
        hi_nz_d = hi_nz_q;
        last_d  = last_q;
        vld_d   = vld_q;
        tens_d  = tens_q;
        units_d = units_q;
        ovf_d   = ovf_q;

        case (state_q)
            SEL: begin
                if (!vld_q[ptr_q] || (cur_in != last_q[ptr_q])) begin
                    state_d = LOAD;
                end else begin
                    ptr_d = ptr_nxt;
                end
            end
            LOAD: begin
                // The port value is sampled only here; later changes are caught
                // on the next visit because last[] records this snapshot.
                snap_d  = cur_in;
                sh_d    = cur_in[CW-1:0];
                bcd_d   = '0;
                cnt_d   = '0;
                hi_nz_d = |cur_in[IO_PORT_W-1:CW];
                state_d = SHIFT;
            end
            SHIFT: begin
                bcd_d = step_bcd;
                sh_d  = step_sh;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNTW'(CW-1)) begin
                    state_d = STORE;
                end
            end
            STORE: begin
                // Anything above 99 (hundreds digit or bits beyond the
                // conversion width) saturates the two-digit display.
                if (hi_nz_q || (bcd_q[11:8] != 4'd0)) begin
                    tens_d[ptr_q]  = BCD_SAT;
                    units_d[ptr_q] = BCD_SAT;
                    ovf_d[ptr_q]   = 1'b1;
                end else begin
                    tens_d[ptr_q]  = bcd_q[7:4];
                    units_d[ptr_q] = bcd_q[3:0];
                    ovf_d[ptr_q]   = 1'b0;
                end
                last_d[ptr_q] = snap_q;
                vld_d[ptr_q]  = 1'b1;
                ptr_d         = ptr_nxt;
                state_d       = SEL;
            end
            default: state_d = SEL;
        endcase

        busy_d = (state_d != SEL);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= SEL;
            ptr_q   <= '0;
            busy_q  <= 1'b0;
            snap_q  <= '0;
            sh_q    <= '0;
            bcd_q   <= '0;
            cnt_q   <= '0;
            hi_nz_q <= 1'b0;
            vld_q   <= '0;
            ovf_q   <= '0;
            for (int p = 0; p < NPORT; p++) begin
                last_q[p]  <= '0;
                tens_q[p]  <= '0;
                units_q[p] <= '0;
            end
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            busy_q  <= busy_d;
            snap_q  <= snap_d;
            sh_q    <= sh_d;
            bcd_q   <= bcd_d;
            cnt_q   <= cnt_d;
            hi_nz_q <= hi_nz_d;
            vld_q   <= vld_d;
            ovf_q   <= ovf_d;
            last_q  <= last_d;
            tens_q  <= tens_d;
            units_q <= units_d;
        end
    end

endmodule

// File: tb/tb_dec_conv_sched.sv
// Directed bench for dec_conv_sched: cold sweep, idle skipping, saturation boundaries,
// mid-conversion change, asynchronous reset during a conversion and change latency.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_dec_conv_sched;

    logic clk;
    logic reset;

    int vec_cnt = 0;
    int err_cnt = 0;

    dec_conv_sched_if #(.NPORT(3)) bus_if ();

    dec_conv_sched #(.NPORT(3), .CW(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic chk_port(input string tag, input int p, input int t, input int u, input int o);
        chk($sformatf("%s_p%0d_tens", tag, p),  32'(bus_if.tens[p*4 +: 4]),  t);
        chk($sformatf("%s_p%0d_units", tag, p), 32'(bus_if.units[p*4 +: 4]), u);
        chk($sformatf("%s_p%0d_ovf", tag, p),   32'(bus_if.ovf[p]),          o);
    endtask

    task automatic set_port(input int p, input logic [31:0] v);
        bus_if.in_data[p*32 +: 32] = v;
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Hold reset across two falling edges, loading the given port values, and
    // release on a falling edge: the next rising edge is cycle 1.
    task automatic reset_with(input logic [31:0] v0, input logic [31:0] v1, input logic [31:0] v2);
        reset = 1'b1;
        set_port(0, v0);
        set_port(1, v1);
        set_port(2, v2);
        cycles(2);
        reset = 1'b0;
    endtask

    // Single-port change with the other ports quiet: must show within 33 cycles.
    task automatic bound_case(input string tag, input logic [31:0] v, input int t, input int u, input int o);
        set_port(0, v);
        cycles(33);
        chk_port(tag, 0, t, u, o);
    endtask

    initial begin
        reset          = 1'b1;
        bus_if.in_data = '0;
        cycles(2);

        // ---------------- reset state ----------------
        chk("rst_busy", 32'(bus_if.busy), 0);
        chk("rst_ptr",  32'(bus_if.cur_port), 0);
        for (int p = 0; p < 3; p++) chk_port("rst", p, 0, 0, 0);

        // ---------------- cold convert ----------------
        reset_with(32'd47, 32'd12, 32'd25);
        cycles(1);
        chk("cold_busy_load", 32'(bus_if.busy), 1);
        cycles(32);
        chk_port("cold", 0, 4, 7, 0);
        chk_port("cold", 1, 1, 2, 0);
        chk_port("cold", 2, 2, 5, 0);

        // ---------------- idle skip ----------------
        for (int k = 0; k < 100; k++) begin
            chk("idle_busy", 32'(bus_if.busy), 0);
            chk("idle_ptr",  32'(bus_if.cur_port), k % 3);
            cycles(1);
        end
        chk_port("idle", 0, 4, 7, 0);
        chk_port("idle", 1, 1, 2, 0);
        chk_port("idle", 2, 2, 5, 0);

        // ---------------- boundaries on port0 ----------------
        bound_case("b99",   32'd99,    9, 9, 0);
        bound_case("b100",  32'd100,   9, 9, 1);
        bound_case("b256",  32'h100,   9, 9, 1);
        bound_case("b0",    32'd0,     0, 0, 0);
        bound_case("b255",  32'd255,   9, 9, 1);
        bound_case("b60",   32'd60,    6, 0, 0);

        // ---------------- mid-conversion change ----------------
        // port1 is selected at cycle 12, LOAD 12-13, SHIFT 13-21, STORE 21-22.
        reset_with(32'd47, 32'd12, 32'd25);
        cycles(15);
        chk("mid_busy",  32'(bus_if.busy), 1);
        chk("mid_ptr",   32'(bus_if.cur_port), 1);
        set_port(1, 32'd30);
        cycles(7);
        chk_port("mid_store", 1, 1, 2, 0);
        // port2 stores at 33, port0 skipped at 34, port1 reselected at 35, stores at 45.
        cycles(22);
        chk_port("mid_stale", 1, 1, 2, 0);
        cycles(1);
        chk_port("mid_reconv", 1, 3, 0, 0);
        chk_port("mid_other", 0, 4, 7, 0);
        chk_port("mid_other", 2, 2, 5, 0);

        // ---------------- reset mid-operation ----------------
        // port2 is selected at cycle 23 and is in SHIFT at cycle 27.
        reset_with(32'd47, 32'd12, 32'd25);
        cycles(27);
        chk("rmid_busy_pre", 32'(bus_if.busy), 1);
        chk("rmid_ptr_pre",  32'(bus_if.cur_port), 2);
        reset = 1'b1;
        set_port(0, 32'd88);
        set_port(1, 32'd5);
        set_port(2, 32'd63);
        #1;
        chk("rmid_busy", 32'(bus_if.busy), 0);
        chk("rmid_ptr",  32'(bus_if.cur_port), 0);
        for (int p = 0; p < 3; p++) chk_port("rmid", p, 0, 0, 0);
        cycles(1);
        reset = 1'b0;
        cycles(33);
        chk_port("rmid_reconv", 0, 8, 8, 0);
        chk_port("rmid_reconv", 1, 0, 5, 0);
        chk_port("rmid_reconv", 2, 6, 3, 0);

        // ---------------- change latency under load ----------------
        set_port(0, 32'd58);
        for (int k = 0; k < 33; k++) begin
            set_port(1, 32'(k + 1));
            set_port(2, 32'(k + 50));
            cycles(1);
        end
        chk_port("lat", 0, 5, 8, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
